// File: rtl/tcm_arb_pkg.sv
// rtl/tcm_arb_pkg.sv - shared types and default window constants for the TCM port-1 arbiter
package tcm_arb_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          WIN_BITS  = 16;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_L = 1'b1
    } owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } tcm_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with loader lock and last-grant register
module rr_arb2
    import tcm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req_d,
    input  logic       req_l,
    input  logic       lock,
    output logic [1:0] grant
);

    owner_t last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            // A locked loader burst keeps the port even when D is waiting.
            if (last_grant == OWN_L && lock && req_l) begin
                grant = 2'b10;
            end else if (req_d && req_l) begin
                grant = (last_grant == OWN_D) ? 2'b10 : 2'b01;
            end else if (req_d) begin
                grant = 2'b01;
            end else if (req_l) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_L;
        end else if (|grant) begin
            last_grant <= grant[1] ? OWN_L : OWN_D;
        end
    end

endmodule

// File: rtl/tcm_port_arb.sv
// rtl/tcm_port_arb.sv - port-1 arbiter/sequencer for the dual-port TCM (data stage vs. loader)
module tcm_port_arb
    import tcm_arb_pkg::owner_t;
    import tcm_arb_pkg::tcm_req_t;
    import tcm_arb_pkg::OWN_D;
    import tcm_arb_pkg::OWN_L;
#(
    parameter logic [31:0] BASE_ADDR = tcm_arb_pkg::BASE_ADDR,
    parameter int          WIN_BITS  = tcm_arb_pkg::WIN_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  d_valid_i,
    input  logic                  l_valid_i,
    output logic                  d_ready_o,
    output logic                  l_ready_o,
    input  logic [31:0]           d_addr_i,
    input  logic [31:0]           l_addr_i,
    input  logic [31:0]           d_wdata_i,
    input  logic [31:0]           l_wdata_i,
    input  logic [3:0]            d_wstrb_i,
    input  logic [3:0]            l_wstrb_i,
    input  logic                  l_lock_i,
    output logic                  d_rvalid_o,
    output logic                  l_rvalid_o,
    output logic [31:0]           d_rdata_o,
    output logic [31:0]           l_rdata_o,
    output logic                  d_err_o,
    output logic                  l_err_o,
    output logic [WIN_BITS-3:0]   ram_addr_o,
    output logic [31:0]           ram_data_o,
    output logic [3:0]            ram_wr_o,
    input  logic [31:0]           ram_data_i,
    output logic [15:0]           d_grants_o,
    output logic [15:0]           l_grants_o
);

    tcm_req_t            d_req, l_req, sel;
    logic [1:0]          grant;
    logic                accept, in_win, do_ram;
    logic [31:0]         offset;
    logic [WIN_BITS-3:0] addr_q;
    logic [31:0]         data_q;
    logic                pend_valid, pend_err;
    owner_t              pend_owner;

    assign d_req = '{addr: d_addr_i, wdata: d_wdata_i, wstrb: d_wstrb_i};
    assign l_req = '{addr: l_addr_i, wdata: l_wdata_i, wstrb: l_wstrb_i};

    // Reset gates the grant so no ready can leak out while rst_i is low.
    rr_arb2 u_arb (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (rst_i),
        .req_d (d_valid_i),
        .req_l (l_valid_i),
        .lock  (l_lock_i),
        .grant (grant)
    );

    assign d_ready_o = grant[0];
    assign l_ready_o = grant[1];
    assign accept    = |grant;
    assign sel       = grant[1] ? l_req : d_req;

    // Unsigned wrap makes addresses below BASE_ADDR land out of window too.
    assign offset = sel.addr - BASE_ADDR;
    assign in_win = (offset >> WIN_BITS) == 32'd0;
    assign do_ram = accept && in_win;

    assign ram_addr_o = do_ram ? offset[WIN_BITS-1:2] : addr_q;
    assign ram_data_o = do_ram ? sel.wdata : data_q;
    assign ram_wr_o   = do_ram ? sel.wstrb : 4'b0000;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q     <= '0;
            data_q     <= '0;
            pend_valid <= 1'b0;
            pend_owner <= OWN_D;
            pend_err   <= 1'b0;
            d_grants_o <= '0;
            l_grants_o <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_owner <= grant[1] ? OWN_L : OWN_D;
                pend_err   <= !in_win;
            end
            if (do_ram) begin
                addr_q <= offset[WIN_BITS-1:2];
                data_q <= sel.wdata;
            end
            if (grant[0] && d_grants_o != 16'hFFFF) d_grants_o <= d_grants_o + 16'd1;
            if (grant[1] && l_grants_o != 16'hFFFF) l_grants_o <= l_grants_o + 16'd1;
        end
    end

    assign d_rvalid_o = pend_valid && pend_owner == OWN_D;
    assign l_rvalid_o = pend_valid && pend_owner == OWN_L;
    assign d_err_o    = d_rvalid_o && pend_err;
    assign l_err_o    = l_rvalid_o && pend_err;
    assign d_rdata_o  = (d_rvalid_o && !pend_err) ? ram_data_i : 32'd0;
    assign l_rdata_o  = (l_rvalid_o && !pend_err) ? ram_data_i : 32'd0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// tb/tb_tcm_port_arb.sv - self-checking bench for tcm_port_arb with RAM model and reference model
module tb_tcm_port_arb;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        d_valid_i = 1'b0, l_valid_i = 1'b0, l_lock_i = 1'b0;
    logic        d_ready_o, l_ready_o;
    logic [31:0] d_addr_i = '0, l_addr_i = '0, d_wdata_i = '0, l_wdata_i = '0;
    logic [3:0]  d_wstrb_i = '0, l_wstrb_i = '0;
    logic        d_rvalid_o, l_rvalid_o, d_err_o, l_err_o;
    logic [31:0] d_rdata_o, l_rdata_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_data_o, ram_q;
    logic [3:0]  ram_wr_o;
    logic [15:0] d_grants_o, l_grants_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcm_port_arb #(.BASE_ADDR(32'h0000_0000), .WIN_BITS(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .d_valid_i(d_valid_i), .l_valid_i(l_valid_i),
        .d_ready_o(d_ready_o), .l_ready_o(l_ready_o),
        .d_addr_i(d_addr_i), .l_addr_i(l_addr_i),
        .d_wdata_i(d_wdata_i), .l_wdata_i(l_wdata_i),
        .d_wstrb_i(d_wstrb_i), .l_wstrb_i(l_wstrb_i),
        .l_lock_i(l_lock_i),
        .d_rvalid_o(d_rvalid_o), .l_rvalid_o(l_rvalid_o),
        .d_rdata_o(d_rdata_o), .l_rdata_o(l_rdata_o),
        .d_err_o(d_err_o), .l_err_o(l_err_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
        .ram_data_i(ram_q),
        .d_grants_o(d_grants_o), .l_grants_o(l_grants_o)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 0)      return 32'hCAFEF00D;
        if (i == 2)      return 32'hAABBCCDD;
        if (i == 'h100)  return 32'hDEADBEEF;
        return i * 32'h9E3779B1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM port-1 model: 1-cycle latency, read-first byte-lane writes.
    logic [31:0] mem [0:16383];
    bit          mem_ok = 0;
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 16384; i++) mem[i] <= init_val(i);
            mem_ok <= 1;
        end else begin
            ram_q <= mem[ram_addr_o];
            for (int b = 0; b < 4; b++)
                if (ram_wr_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
        end
    end

    // Reference model: evaluated at each falling edge from the inputs held for the coming rising edge.
    logic [31:0] gold [0:16383];
    bit          gold_ok = 0;
    int          m_last = 1, m_owner = 0, m_cd = 0, m_cl = 0;
    bit          m_pend = 0, m_err = 0;
    logic [31:0] m_rdata = '0, m_wd = '0;
    logic [13:0] m_idx = '0;

    always @(negedge clk) begin
        int          w;
        logic [31:0] a, wd, off;
        logic [3:0]  ws;
        bit          inwin;
        logic [13:0] idx;
        if (!gold_ok) begin
            for (int i = 0; i < 16384; i++) gold[i] = init_val(i);
            gold_ok = 1;
        end
        if (!rst_i) begin
            m_last = 1; m_pend = 0; m_cd = 0; m_cl = 0; m_idx = '0; m_wd = '0;
        end
        check("d_rvalid", d_rvalid_o, m_pend && m_owner == 0);
        check("l_rvalid", l_rvalid_o, m_pend && m_owner == 1);
        if (m_pend && m_owner == 0) begin
            check("d_err", d_err_o, m_err);
            check("d_rdata", d_rdata_o, m_err ? 32'd0 : m_rdata);
        end
        if (m_pend && m_owner == 1) begin
            check("l_err", l_err_o, m_err);
            check("l_rdata", l_rdata_o, m_err ? 32'd0 : m_rdata);
        end
        check("d_grants", d_grants_o, m_cd);
        check("l_grants", l_grants_o, m_cl);

        w = -1;
        if (rst_i) begin
            if (m_last == 1 && l_lock_i && l_valid_i) w = 1;
            else if (d_valid_i && l_valid_i)          w = 1 - m_last;
            else if (d_valid_i)                       w = 0;
            else if (l_valid_i)                       w = 1;
        end
        a  = (w == 1) ? l_addr_i  : d_addr_i;
        wd = (w == 1) ? l_wdata_i : d_wdata_i;
        ws = (w == 1) ? l_wstrb_i : d_wstrb_i;
        off   = a - 32'h0000_0000;
        inwin = off < 32'h0001_0000;
        idx   = off[15:2];

        check("d_ready", d_ready_o, w == 0);
        check("l_ready", l_ready_o, w == 1);
        check("ram_wr", ram_wr_o, (w >= 0 && inwin) ? ws : 4'b0000);
        check("ram_addr", ram_addr_o, (w >= 0 && inwin) ? idx : m_idx);
        check("ram_data", ram_data_o, (w >= 0 && inwin) ? wd : m_wd);

        m_pend = (w >= 0);
        if (w >= 0) begin
            m_owner = w;
            m_err   = !inwin;
            m_rdata = inwin ? gold[idx] : 32'd0;
            if (inwin) begin
                for (int b = 0; b < 4; b++) if (ws[b]) gold[idx][8*b +: 8] = wd[8*b +: 8];
                m_idx = idx;
                m_wd  = wd;
            end
            if (w == 0 && m_cd < 65535) m_cd++;
            if (w == 1 && m_cl < 65535) m_cl++;
            m_last = w;
        end
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic mid;  @(negedge clk); #1; endtask

    task automatic idle;
        d_valid_i = 0; l_valid_i = 0; l_lock_i = 0;
        d_wstrb_i = 0; l_wstrb_i = 0;
    endtask

    task automatic do_reset;
        idle(); rst_i = 0;
        mid();
        check("rst_d_ready", d_ready_o, 1'b0);
        check("rst_ram_wr", ram_wr_o, 4'b0);
        check("rst_ram_addr", ram_addr_o, 14'd0);
        tick(); rst_i = 1;
    endtask

    initial begin
        tick(); tick();
        do_reset();

        // Single D read of word 0x100
        d_valid_i = 1; d_addr_i = 32'h400; d_wstrb_i = 0;
        mid(); check("t1_ready", d_ready_o, 1'b1);
        tick(); idle();
        mid(); check("t1_rvalid", d_rvalid_o, 1'b1);
        check("t1_rdata", d_rdata_o, 32'hDEADBEEF);
        check("t1_err", d_err_o, 1'b0);
        tick();

        // L partial write then read-back of word 2
        l_valid_i = 1; l_addr_i = 32'h8; l_wdata_i = 32'h11223344; l_wstrb_i = 4'b0101;
        mid(); check("t2_wready", l_ready_o, 1'b1);
        tick(); l_wstrb_i = 0;
        mid(); check("t2_wrvalid", l_rvalid_o, 1'b1);
        check("t2_wrdata", l_rdata_o, 32'hAABBCCDD);
        tick(); idle();
        mid(); check("t2_rrvalid", l_rvalid_o, 1'b1);
        check("t2_rdata", l_rdata_o, 32'hAA22CC44);
        tick();
        mid(); check("t2_quiet", l_rvalid_o, 1'b0);
        tick();

        // Contention without lock alternates D, L, ...
        do_reset();
        d_valid_i = 1; l_valid_i = 1; d_addr_i = 32'h10; l_addr_i = 32'h20;
        for (int i = 0; i < 6; i++) begin
            mid(); check("t3_order", d_ready_o, (i % 2) == 0);
            tick();
        end
        idle();
        mid(); check("t3_dcnt", d_grants_o, 16'd3);
        check("t3_lcnt", l_grants_o, 16'd3);
        tick();

        // Loader lock starves D until released
        l_valid_i = 1; l_lock_i = 1;
        mid(); check("t4_lgrant", l_ready_o, 1'b1);
        tick(); d_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            mid(); check("t4_starve", d_ready_o, 1'b0);
            tick();
        end
        l_lock_i = 0;
        mid(); check("t4_release", d_ready_o, 1'b1);
        tick(); idle();

        // Out-of-window write is dropped and flagged
        d_valid_i = 1; d_addr_i = 32'h0001_0000; d_wdata_i = 32'h12345678; d_wstrb_i = 4'hF;
        mid(); check("t5_ready", d_ready_o, 1'b1);
        check("t5_wr", ram_wr_o, 4'b0);
        tick(); d_addr_i = 32'h0; d_wstrb_i = 0;
        mid(); check("t5_rvalid", d_rvalid_o, 1'b1);
        check("t5_err", d_err_o, 1'b1);
        check("t5_rdata", d_rdata_o, 32'd0);
        tick(); idle();
        mid(); check("t5_word0", d_rdata_o, 32'hCAFEF00D);
        check("t5_err0", d_err_o, 1'b0);
        tick();

        // Reset one cycle after an accept drops the pending response
        d_valid_i = 1; d_addr_i = 32'h400;
        mid(); tick(); idle(); rst_i = 0;
        mid(); check("t6_rvalid_rst", d_rvalid_o, 1'b0);
        tick(); rst_i = 1;
        mid(); check("t6_rvalid", d_rvalid_o, 1'b0);
        check("t6_dcnt", d_grants_o, 16'd0);
        check("t6_lcnt", l_grants_o, 16'd0);
        check("t6_addr", ram_addr_o, 14'd0);
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            if (c == 900) rst_i = 0;
            if (c == 902) rst_i = 1;
            d_valid_i = ($urandom % 4) != 0;
            l_valid_i = ($urandom % 2) != 0;
            l_lock_i  = ($urandom % 3) == 0;
            d_addr_i  = (($urandom % 16) == 0) ? ($urandom | 32'h0001_0000) : $urandom_range(0, 127);
            l_addr_i  = (($urandom % 16) == 0) ? ($urandom | 32'h0001_0000) : $urandom_range(0, 127);
            d_wdata_i = $urandom;
            l_wdata_i = $urandom;
            d_wstrb_i = ($urandom % 2) ? 4'($urandom) : 4'b0;
            l_wstrb_i = ($urandom % 2) ? 4'($urandom) : 4'b0;
            tick();
        end
        idle();
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
